// File: rtl/default_slave_if.sv
// AXI4 channel bundle for the default (decode-error) slave port.
// Only the fields the default slave observes or drives are carried.
interface default_slave_if #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
);

  logic [ID_W-1:0]   ARID;
  logic [LEN_W-1:0]  ARLEN;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  logic [ID_W-1:0]   AWID;
  logic [LEN_W-1:0]  AWLEN;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport slave (
    input  ARID, ARLEN, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWLEN, AWVALID,
    output AWREADY,
    input  WDATA, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output ARID, ARLEN, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWLEN, AWVALID,
    input  AWREADY,
    output WDATA, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

endinterface

// File: rtl/default_slave.sv
// AXI4 decode-error slave: drains one unmapped burst at a time and answers DECERR.
// Optional feature: DEFAULT_SLAVE_ERRCNT_EN adds a saturating 16-bit err_cnt output.
module default_slave #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  default_slave_if.slave   axi
`ifdef DEFAULT_SLAVE_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WD   = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]       state;
  logic [ID_W-1:0]  id_q;
  logic [LEN_W-1:0] beat_cnt;

  logic in_rd;
  logic in_wd;
  logic in_wb;
  logic rd_last_hs;
  logic wr_resp_hs;

  // Write data and burst length carry no information for an error response.
  logic unused_inputs;
  assign unused_inputs = ^{axi.WDATA, axi.AWLEN};

  assign in_rd = (state == RD);
  assign in_wd = (state == WD);
  assign in_wb = (state == WB);

  assign rd_last_hs = in_rd && axi.RREADY && (beat_cnt == '0);
  assign wr_resp_hs = in_wb && axi.BREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      id_q     <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Read takes priority when both address channels are valid.
          if (axi.ARVALID) begin
            id_q     <= axi.ARID;
            beat_cnt <= axi.ARLEN;
            state    <= RD;
          end else if (axi.AWVALID) begin
            id_q  <= axi.AWID;
            state <= WD;
          end
        end
        RD: begin
          if (axi.RREADY) begin
            if (beat_cnt == '0) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        WD: begin
          if (axi.WVALID && axi.WLAST) begin
            state <= WB;
          end
        end
        WB: begin
          if (axi.BREADY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; nothing feeds through from inputs.
  assign axi.ARREADY = (state == IDLE);
  assign axi.AWREADY = (state == IDLE);

  assign axi.RVALID  = in_rd;
  assign axi.RID     = in_rd ? id_q : '0;
  assign axi.RDATA   = '0;
  assign axi.RRESP   = in_rd ? RESP_DECERR : 2'b00;
  assign axi.RLAST   = in_rd && (beat_cnt == '0);

  assign axi.WREADY  = in_wd;

  assign axi.BVALID  = in_wb;
  assign axi.BID     = in_wb ? id_q : '0;
  assign axi.BRESP   = in_wb ? RESP_DECERR : 2'b00;

`ifdef DEFAULT_SLAVE_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((rd_last_hs || wr_resp_hs) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = rd_last_hs ^ wr_resp_hs;
`endif

endmodule

// File: doc/default_slave.md
# default_slave

AXI4 decode-error slave that occupies slave index 0 of the crossbar, the "no slave matched" port the arbiter routes unmapped requests to. It accepts one read or write transaction at a time, consumes the full burst, and completes it with a DECERR response so a master issuing an unmapped address never hangs. It sits directly downstream of the arbiter and is driven by the same crossbar muxing as every real slave.

## Interface
- ID_W, 8, slave-side ID width (master ID plus master index bits)
- DATA_W, 32, data bus width
- LEN_W, 4, burst length field width (AxLEN)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- ARID, ARLEN, ARVALID  in  ID_W / LEN_W / 1  read address channel
- ARREADY  out  1
- RID  out  ID_W; RDATA  out  DATA_W; RRESP  out  2; RLAST  out  1; RVALID  out  1
- RREADY  in  1
- AWID, AWLEN, AWVALID  in  ID_W / LEN_W / 1  write address channel
- AWREADY  out  1
- WDATA  in  DATA_W; WLAST  in  1; WVALID  in  1 (WDATA ignored)
- WREADY  out  1
- BID  out  ID_W; BRESP  out  2; BVALID  out  1
- BREADY  in  1

## Operation
- States: IDLE, RD, WD, WB. Exactly one transaction in flight; no overlap between read and write.
- IDLE: ARREADY=1, AWREADY=1 (the arbiter grants only when ready is high, so both stay high while idle). All other outputs 0.
- ARVALID in IDLE: latch ARID, load beat counter with ARLEN, go to RD. If ARVALID and AWVALID are both high, read wins; AW is not accepted (AWREADY drops with the state change).
- AWVALID without ARVALID in IDLE: latch AWID, go to WD.
- RD: RVALID=1, RID=latched ID, RDATA=0, RRESP=2'b11 (DECERR), RLAST=(counter==0).
  - On RVALID&RREADY: decrement the counter.
  - On the RLAST handshake: go to IDLE.
  - ARLEN=0 gives a single beat with RLAST=1.
  - ARLEN=2^LEN_W-1 gives 16 beats and must not wrap early.
- WD: WREADY=1. Discard data on each WVALID&WREADY. On a WLAST handshake go to WB. Termination follows WLAST only; AWLEN is not checked.
- WB: BVALID=1, BID=latched ID, BRESP=2'b11. On BREADY go to IDLE.
- Outputs hold stable while VALID is high and READY is low.
- rst during any state: next cycle is IDLE with all registers and outputs at reset values, and the in-flight transaction is abandoned.

## Timing
- Reset values: ARREADY=1, AWREADY=1; RVALID, RLAST, WREADY, BVALID=0; RID, BID, RDATA=0; RRESP, BRESP=0.
- AR handshake at cycle N: first RVALID at N+1. A beat accepted at cycle K: next beat at K+1 (full throughput).
- Last R handshake at cycle K: ARREADY/AWREADY=1 at K+1.
- AW handshake at N: WREADY at N+1. W beats presented before N+1 are not accepted.
- WLAST handshake at K: BVALID at K+1. B handshake at K: IDLE and ready at K+1.
- Minimum read occupancy: ARLEN+2 cycles. Minimum write occupancy: beats+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Configuration
- DEFAULT_SLAVE_ERRCNT_EN defined:
  - Adds output err_cnt (16 bits).
  - Increments by 1 on each completed R-last or B handshake.
  - Saturates at 16'hFFFF; reset value 0.
  - Lets software and debug observe unmapped accesses.
- Macro undefined: no err_cnt port or logic; behaviour is otherwise identical.

## Test plan
- Reset held 3 cycles, then released. Required: ARREADY=AWREADY=1 and all VALIDs 0 on the first cycle after release.
- AR with ARID=8'h15, ARLEN=3, RREADY=1. Required: 4 beats on consecutive cycles from N+1, RRESP=2'b11, RDATA=0, RID=8'h15, RLAST only on beat 4, ARREADY high the cycle after.
- AR with ARLEN=0 and RREADY low for 5 cycles. Required: RVALID/RLAST/RID held stable for 5 cycles; completes on the first RREADY cycle.
- AW with AWID=8'h2A, then 2 W beats with WVALID gapped by one cycle, WLAST on beat 2, BREADY=1. Required: BVALID the cycle after WLAST, BID=8'h2A, BRESP=2'b11, idle the next cycle.
- ARVALID and AWVALID asserted in the same cycle. Required: read accepted, AW left pending, write served after the read completes.
- rst asserted mid-burst (beat 2 of ARLEN=7). Required: all outputs at reset values the next cycle; with ERRCNT_EN, err_cnt=0 and it counts 1 after a subsequent full transaction.
